rename_dispatch: RTL and testbench
==================================

RENAME_DISPATCH -- requirements
Module: rename_dispatch

Interface
REQ-001 SHALL have ports (name, direction, width, meaning):
- CLK  in  1  single clock, all state on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- STALL  in  1  global pipeline freeze.
- FLUSH  in  1  synchronous misprediction flush.
- decode_valid  in  1  decoded instruction present.
- decode_rs, decode_rt, decode_wr  in  5 each  arch source A, source B, destination.
- decode_wr_en  in  1  instruction writes decode_wr.
- decode_payload  in  152  opaque decode fields.
- decode_instr_num  in  32  ROB sequence number.
- issue_halt  in  1  issue queue full.
- exe_broadcast  in  1  result broadcast valid.
- exe_broadcast_map  in  6  physical register written.
- commit_valid  in  1  ROB retiring one instruction.
- commit_arch_reg  in  5  arch destination being retired.
- commit_new_map  in  6  its physical register.
- commit_old_map  in  6  previous mapping to free.
- decode_stall  out  1  instruction not accepted this cycle.
- rename_enque  out  1  issueinfo valid.
- rename_issueinfo  out  170  {payload[151:0], MapWr, MapB, MapA}, MapA in [5:0].
- rename_instr_num  out  32  sequence number.
- rename_old_map  out  6  prior mapping of destination, for ROB.
- busy  out  64  bit p = 1 means phys reg p holds a valid value.
REQ-002 SHALL take the clock as CLK and the reset as RESET, asynchronous and active-low; CLK is the only clock.

Function
REQ-003 SHALL hold RAT[32]x6 (speculative), ARAT[32]x6 (committed), free_vec[64], busy[64]; phys reg 0 is hardwired to arch reg 0, never free, busy[0]=1 always.
REQ-004 SHALL define need_alloc = decode_wr_en && decode_wr!=0.
REQ-005 SHALL define accept = decode_valid && !STALL && !FLUSH && !issue_halt && (!need_alloc || free_vec!=0).
REQ-006 SHALL drive decode_stall = decode_valid && !accept, combinationally.
REQ-007 On accept: MapA=RAT[rs], MapB=RAT[rt]; rs or rt equal to 0 gives 0.
REQ-008 On accept with need_alloc: allocate the lowest-index set bit p of free_vec, clear free_vec[p], clear busy[p], set RAT[wr]=p, and capture old_map=RAT[wr] before the update.
REQ-009 On accept without need_alloc: MapWr=0, old_map=0, and RAT is not modified.
REQ-010 Latency is one cycle: the edge after accept registers rename_enque=1, issueinfo, instr_num and old_map.
REQ-011 On a non-accept cycle, rename_enque<=0 and all other outputs hold their value; under STALL everything holds, including rename_enque.
REQ-012 exe_broadcast with map!=0 SHALL set busy[map]=1; if the same p is allocated that cycle, the allocation clear wins.
REQ-013 commit_valid SHALL set ARAT[commit_arch_reg]=commit_new_map and free_vec[commit_old_map]=1 (ignored if old_map==0).
REQ-014 commit and broadcast SHALL be processed during STALL; commit is processed during FLUSH.
REQ-015 A freed register is not allocatable in the same cycle; there is no bypass.
REQ-016 FLUSH SHALL, in one cycle: RAT<=ARAT including any same-cycle commit; free_vec[p]=1 iff p!=0 and p is not in that ARAT; busy<=all ones; rename_enque<=0; no accept.
REQ-017 Two RAT entries SHALL never hold the same nonzero p; a bench assertion checks this plus popcount(free_vec)+31 == 63 at quiescence.

Reset
REQ-018 On RESET low: RAT[a]=ARAT[a]=a; free_vec=64'hFFFFFFFF_00000000; busy=all ones; rename_enque=0, issueinfo=0, instr_num=0, old_map=0; decode_stall follows REQ-006.
REQ-019 Reset mid-operation SHALL abandon any in-flight output and restore REQ-018 state immediately (asynchronous).

Verification
REQ-020 After reset, rs=1, rt=2, wr=3 -> next cycle MapA=1, MapB=2, MapWr=32, old_map=3, busy[32]=0, RAT[3]=32.
REQ-021 Back-to-back writes to wr=3 then read rs=3 -> second MapWr=33 with old_map=32; the reader gets MapA=33.
REQ-022 Allocate 32 times without commit, then a 33rd writer -> decode_stall=1, rename_enque=0; commit old_map=5 -> accept the following cycle with MapWr=5.
REQ-023 Broadcast map=40 with busy[40]=0 -> busy[40]=1 next cycle; broadcast map=0 -> no change.
REQ-024 Rename wr=7 (p=32), commit nothing, FLUSH -> RAT[7]=7, free_vec[32]=1, busy all ones, rename_enque=0.
REQ-025 issue_halt=1 or STALL=1 with decode_valid=1 -> no allocation and outputs held; release -> same instruction accepted once.

Source files
------------

// File: rtl/rename_dispatch.sv
// ============================================================================
// Module   : rename_dispatch
// Purpose  : Register renaming with speculative/committed map tables, free-list
//            allocation and busy scoreboard; one-cycle registered dispatch.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rename_dispatch (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         STALL,
  input  logic         FLUSH,
  input  logic         decode_valid,
  input  logic [4:0]   decode_rs,
  input  logic [4:0]   decode_rt,
  input  logic [4:0]   decode_wr,
  input  logic         decode_wr_en,
  input  logic [151:0] decode_payload,
  input  logic [31:0]  decode_instr_num,
  input  logic         issue_halt,
  input  logic         exe_broadcast,
  input  logic [5:0]   exe_broadcast_map,
  input  logic         commit_valid,
  input  logic [4:0]   commit_arch_reg,
  input  logic [5:0]   commit_new_map,
  input  logic [5:0]   commit_old_map,
  output logic         decode_stall,
  output logic         rename_enque,
  output logic [169:0] rename_issueinfo,
  output logic [31:0]  rename_instr_num,
  output logic [5:0]   rename_old_map,
  output logic [63:0]  busy
);

  localparam logic [63:0] c_FREE_RESET = 64'hFFFFFFFF_00000000;

  logic [5:0]  r_rat  [32];
  logic [5:0]  r_arat [32];
  logic [63:0] r_free_vec;
  logic [63:0] r_busy;

  logic [5:0]  w_rat_next  [32];
  logic [5:0]  w_arat_next [32];
  logic [63:0] w_free_next;
  logic [63:0] w_busy_next;
  logic [63:0] w_used;

  logic        w_need_alloc;
  logic        w_accept;
  logic        w_alloc;
  logic [5:0]  w_alloc_idx;
  logic [5:0]  w_map_a;
  logic [5:0]  w_map_b;
  logic [5:0]  w_map_wr;
  logic [5:0]  w_old_map;

  always_comb begin
    w_need_alloc = decode_wr_en && (decode_wr != 5'd0);
    w_accept     = decode_valid && !STALL && !FLUSH && !issue_halt &&
                   (!w_need_alloc || (r_free_vec != 64'd0));
    w_alloc      = w_accept && w_need_alloc;
    decode_stall = decode_valid && !w_accept;
  end

  // Lowest-index free register wins.
  always_comb begin
    w_alloc_idx = 6'd0;
    for (int i = 63; i >= 0; i--) begin
      if (r_free_vec[i]) begin
        w_alloc_idx = 6'(i);
      end
    end
  end

  always_comb begin
    w_map_a   = (decode_rs == 5'd0) ? 6'd0 : r_rat[decode_rs];
    w_map_b   = (decode_rt == 5'd0) ? 6'd0 : r_rat[decode_rt];
    w_map_wr  = w_need_alloc ? w_alloc_idx : 6'd0;
    w_old_map = w_need_alloc ? r_rat[decode_wr] : 6'd0;
  end

  always_comb begin
    for (int a = 0; a < 32; a++) begin
      w_arat_next[a] = r_arat[a];
    end
    if (commit_valid && (commit_arch_reg != 5'd0)) begin
      w_arat_next[commit_arch_reg] = commit_new_map;
    end
  end

  // A flush rebuilds the free list from the committed map, same-cycle commit included.
  always_comb begin
    w_used = 64'd1;
    for (int a = 0; a < 32; a++) begin
      w_used[w_arat_next[a]] = 1'b1;
    end
  end

  always_comb begin
    for (int a = 0; a < 32; a++) begin
      w_rat_next[a] = FLUSH ? w_arat_next[a] : r_rat[a];
    end
    if (w_alloc) begin
      w_rat_next[decode_wr] = w_alloc_idx;
    end
  end

  always_comb begin
    w_free_next = r_free_vec;
    if (FLUSH) begin
      w_free_next = ~w_used;
    end else begin
      if (commit_valid && (commit_old_map != 6'd0)) begin
        w_free_next[commit_old_map] = 1'b1;
      end
      if (w_alloc) begin
        w_free_next[w_alloc_idx] = 1'b0;
      end
    end
    w_free_next[0] = 1'b0;
  end

  always_comb begin
    w_busy_next = r_busy;
    if (FLUSH) begin
      w_busy_next = '1;
    end else begin
      if (exe_broadcast && (exe_broadcast_map != 6'd0)) begin
        w_busy_next[exe_broadcast_map] = 1'b1;
      end
      if (w_alloc) begin
        w_busy_next[w_alloc_idx] = 1'b0;
      end
    end
    w_busy_next[0] = 1'b1;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int a = 0; a < 32; a++) begin
        r_rat[a]  <= 6'(a);
        r_arat[a] <= 6'(a);
      end
      r_free_vec <= c_FREE_RESET;
      r_busy     <= '1;
    end else begin
      r_rat      <= w_rat_next;
      r_arat     <= w_arat_next;
      r_free_vec <= w_free_next;
      r_busy     <= w_busy_next;
    end
  end

  // Under STALL the outputs freeze; a flush still retracts the valid.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rename_enque     <= 1'b0;
      rename_issueinfo <= '0;
      rename_instr_num <= '0;
      rename_old_map   <= '0;
    end else if (FLUSH) begin
      rename_enque <= 1'b0;
    end else if (!STALL) begin
      rename_enque <= w_accept;
      if (w_accept) begin
        rename_issueinfo <= {decode_payload, w_map_wr, w_map_b, w_map_a};
        rename_instr_num <= decode_instr_num;
        rename_old_map   <= w_old_map;
      end
    end
  end

  assign busy = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_rename_dispatch.sv
// ============================================================================
// Module   : tb_rename_dispatch
// Purpose  : Scoreboard bench for rename_dispatch with directed vectors.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rename_dispatch;

  logic         CLK = 1'b0;
  logic         RESET, STALL, FLUSH, decode_valid, decode_wr_en, issue_halt;
  logic [4:0]   decode_rs, decode_rt, decode_wr, commit_arch_reg;
  logic [151:0] decode_payload;
  logic [31:0]  decode_instr_num;
  logic         exe_broadcast, commit_valid;
  logic [5:0]   exe_broadcast_map, commit_new_map, commit_old_map;
  logic         decode_stall, rename_enque;
  logic [169:0] rename_issueinfo;
  logic [31:0]  rename_instr_num;
  logic [5:0]   rename_old_map;
  logic [63:0]  busy;

  rename_dispatch dut (
    .CLK(CLK), .RESET(RESET), .STALL(STALL), .FLUSH(FLUSH),
    .decode_valid(decode_valid), .decode_rs(decode_rs), .decode_rt(decode_rt),
    .decode_wr(decode_wr), .decode_wr_en(decode_wr_en),
    .decode_payload(decode_payload), .decode_instr_num(decode_instr_num),
    .issue_halt(issue_halt), .exe_broadcast(exe_broadcast),
    .exe_broadcast_map(exe_broadcast_map), .commit_valid(commit_valid),
    .commit_arch_reg(commit_arch_reg), .commit_new_map(commit_new_map),
    .commit_old_map(commit_old_map), .decode_stall(decode_stall),
    .rename_enque(rename_enque), .rename_issueinfo(rename_issueinfo),
    .rename_instr_num(rename_instr_num), .rename_old_map(rename_old_map),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [169:0] info;
    logic [31:0]  num;
    logic [5:0]   old;
  } exp_t;

  exp_t q[$];
  int   compared   = 0;
  int   mismatched = 0;
  logic stall_at_edge = 1'b0;

  function automatic logic [151:0] pl(input logic [31:0] n);
    return {n[23:0], n, ~n, n ^ 32'hA5A5A5A5, n};
  endfunction

  task automatic chk(input string name, input logic [169:0] act, input logic [169:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] wr,
                       input logic wr_en, input logic [31:0] num);
    decode_valid     = 1'b1;
    decode_rs        = rs;
    decode_rt        = rt;
    decode_wr        = wr;
    decode_wr_en     = wr_en;
    decode_instr_num = num;
    decode_payload   = pl(num);
  endtask

  task automatic push(input logic [5:0] ma, input logic [5:0] mb, input logic [5:0] mw,
                      input logic [5:0] old, input logic [31:0] num);
    exp_t e;
    e.info = {pl(num), mw, mb, ma};
    e.num  = num;
    e.old  = old;
    q.push_back(e);
  endtask

  task automatic invariant(input string name);
    int dups;
    int pc;
    dups = 0;
    for (int i = 0; i < 32; i++)
      for (int j = i + 1; j < 32; j++)
        if (dut.r_rat[i] != 6'd0 && dut.r_rat[i] == dut.r_rat[j]) dups++;
    pc = $countones(dut.r_free_vec);
    chk({name, "_dup_map"}, 170'(dups), 170'd0);
    chk({name, "_free_count"}, 170'(pc + 31), 170'd63);
  endtask

  always @(posedge CLK) stall_at_edge <= STALL;

  // Monitor: each freshly registered output (not a stall hold) pops one expectation.
  always @(negedge CLK) begin
    if (RESET && rename_enque && !stall_at_edge) begin
      if (q.size() == 0) begin
        chk("unexpected_enque", 170'(rename_instr_num), 170'h0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("issueinfo", rename_issueinfo, e.info);
        chk("instr_num", 170'(rename_instr_num), 170'(e.num));
        chk("old_map", 170'(rename_old_map), 170'(e.old));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] exp_busy;
    logic [4:0]  wr;
    RESET = 1'b0; STALL = 1'b0; FLUSH = 1'b0; issue_halt = 1'b0;
    decode_valid = 1'b0; decode_rs = '0; decode_rt = '0; decode_wr = '0;
    decode_wr_en = 1'b0; decode_payload = '0; decode_instr_num = '0;
    exe_broadcast = 1'b0; exe_broadcast_map = '0;
    commit_valid = 1'b0; commit_arch_reg = '0; commit_new_map = '0; commit_old_map = '0;

    repeat (2) step();
    chk("rst_enque", 170'(rename_enque), 170'd0);
    chk("rst_issueinfo", rename_issueinfo, 170'd0);
    chk("rst_instr_num", 170'(rename_instr_num), 170'd0);
    chk("rst_old_map", 170'(rename_old_map), 170'd0);
    chk("rst_busy", 170'(busy), 170'(64'hFFFFFFFF_FFFFFFFF));
    chk("rst_decode_stall", 170'(decode_stall), 170'd0);
    invariant("rst");
    RESET = 1'b1;
    step();

    // First rename after reset
    drive(1, 2, 3, 1, 100); push(1, 2, 32, 3, 100); step();
    decode_valid = 1'b0;
    chk("busy32_cleared", 170'(busy[32]), 170'd0);

    // Back-to-back writes to r3, then a reader of r3
    drive(0, 0, 3, 1, 101); push(0, 0, 33, 32, 101); step();
    drive(3, 3, 0, 0, 102); push(33, 33, 0, 0, 102); step();
    decode_valid = 1'b0;

    // Drain the free list: p34..p61 to r4..r31, p62 to r1, p63 to r2
    for (int k = 0; k < 30; k++) begin
      wr = (k < 28) ? 5'(4 + k) : 5'(k - 27);
      drive(0, 0, wr, 1, 32'(200 + k));
      push(0, 0, 6'(34 + k), 6'(wr), 32'(200 + k));
      step();
    end
    drive(0, 0, 5, 1, 300);
    #2 chk("full_decode_stall", 170'(decode_stall), 170'd1);
    step();
    chk("full_no_enque", 170'(rename_enque), 170'd0);
    commit_valid = 1'b1; commit_arch_reg = 5; commit_new_map = 35; commit_old_map = 5;
    #2 chk("no_bypass_stall", 170'(decode_stall), 170'd1);
    step();
    commit_valid = 1'b0;
    push(0, 0, 5, 35, 300); step();
    decode_valid = 1'b0;

    // Broadcasts
    exe_broadcast = 1'b1; exe_broadcast_map = 40; step();
    chk("busy40_set", 170'(busy[40]), 170'd1);
    exe_broadcast_map = 0; step();
    exe_broadcast = 1'b0;
    exp_busy = 64'h00000000_FFFFFFFF;
    exp_busy[5] = 1'b0;
    exp_busy[40] = 1'b1;
    chk("busy_after_bcast0", 170'(busy), 170'(exp_busy));

    // Flush with a pending decode: RAT returns to ARAT (r5 -> p35)
    FLUSH = 1'b1; drive(0, 0, 6, 1, 400);
    #2 chk("flush_decode_stall", 170'(decode_stall), 170'd1);
    step();
    FLUSH = 1'b0; decode_valid = 1'b0;
    chk("flush_enque", 170'(rename_enque), 170'd0);
    chk("flush_busy", 170'(busy), 170'(64'hFFFFFFFF_FFFFFFFF));
    invariant("flush");
    drive(5, 6, 6, 1, 401); push(35, 6, 5, 6, 401); step();

    // Asynchronous reset abandons an in-flight output
    drive(1, 0, 2, 1, 500);
    @(posedge CLK); #2;
    RESET = 1'b0; decode_valid = 1'b0;
    #1;
    chk("async_rst_enque", 170'(rename_enque), 170'd0);
    chk("async_rst_info", rename_issueinfo, 170'd0);
    chk("async_rst_busy", 170'(busy), 170'(64'hFFFFFFFF_FFFFFFFF));
    step();
    RESET = 1'b1;
    invariant("async_rst");

    // Rename r7 then flush with nothing committed
    drive(0, 0, 7, 1, 600); push(0, 0, 32, 7, 600); step();
    decode_valid = 1'b0; FLUSH = 1'b1; step();
    FLUSH = 1'b0;
    chk("flush2_enque", 170'(rename_enque), 170'd0);
    chk("flush2_busy", 170'(busy), 170'(64'hFFFFFFFF_FFFFFFFF));
    drive(7, 0, 8, 1, 601); push(7, 0, 32, 8, 601); step();

    // issue_halt holds the instruction until released
    issue_halt = 1'b1; drive(0, 0, 9, 1, 602);
    #2 chk("halt_decode_stall", 170'(decode_stall), 170'd1);
    step();
    chk("halt_no_enque", 170'(rename_enque), 170'd0);
    step();
    issue_halt = 1'b0; push(0, 0, 33, 9, 602); step();
    decode_valid = 1'b0; step();

    // STALL freezes the registered output
    drive(0, 0, 10, 1, 603); push(0, 0, 34, 10, 603); step();
    STALL = 1'b1; drive(0, 0, 11, 1, 604);
    #2 chk("stall_decode_stall", 170'(decode_stall), 170'd1);
    step();
    chk("stall_hold_enque", 170'(rename_enque), 170'd1);
    chk("stall_hold_mapwr", 170'(rename_issueinfo[17:12]), 170'd34);
    step();
    chk("stall_hold_num", 170'(rename_instr_num), 170'd603);
    STALL = 1'b0; push(0, 0, 35, 11, 604); step();

    // Allocation clear beats a same-cycle broadcast to the same register
    drive(0, 0, 12, 1, 605); push(0, 0, 36, 12, 605);
    exe_broadcast = 1'b1; exe_broadcast_map = 36; step();
    exe_broadcast = 1'b0; decode_valid = 1'b0;
    chk("alloc_beats_bcast", 170'(busy[36]), 170'd0);

    repeat (3) step();
    chk("queue_drained", 170'(q.size()), 170'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
